pad_poll_scheduler: RTL and testbench

- Sequences the controller serial engine for two pad ports and shares that one engine between them.
- Issues one-cycle start pulses and routes the engine ATT line to the selected port.
- On each transaction: captures a per-port button/joystick snapshot, or recovers the engine after an error or timeout.
- Sits between the engine and the register/bus interface that software and the rest of the system read.

---
 rtl/pad_poll_scheduler.sv | 142 ++++++++++++++
 tb/tb_pad_poll_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_poll_scheduler.sv
// rtl/pad_poll_scheduler.sv - two-port pad polling sequencer sharing one serial engine
module pad_poll_scheduler #(
  parameter logic [15:0] GAP_CYCLES     = 16'd5000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000,
  parameter logic [3:0]  RST_CYCLES     = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        port1_en,
  input  logic        engine_att,
  input  logic        engine_err,
  input  logic [15:0] engine_btn,
  input  logic [31:0] engine_joy,
  input  logic [3:0]  engine_type,
  output logic        engine_start,
  output logic        engine_rst,
  output logic        port_sel,
  output logic [1:0]  port_att_n,
  output logic [15:0] btn0,
  output logic [15:0] btn1,
  output logic [31:0] joy0,
  output logic [31:0] joy1,
  output logic [3:0]  type0,
  output logic [3:0]  type1,
  output logic [1:0]  valid,
  output logic [1:0]  upd,
  output logic [7:0]  err_cnt0,
  output logic [7:0]  err_cnt1
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_BUSY    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [19:0] cnt;
  logic        seen_low;
  logic        busy_timeout;
  logic        gap_done;
  logic        rec_done;
  logic        enter_recover;

  // One shared counter serves BUSY timeout, RECOVER hold and GAP spacing;
  // it restarts from zero on every state change.
  assign busy_timeout  = (cnt == TIMEOUT_CYCLES - 20'd1);
  assign gap_done      = (cnt == {4'd0, GAP_CYCLES} - 20'd1);
  assign rec_done      = (cnt == {16'd0, RST_CYCLES} - 20'd1);
  assign enter_recover = (state == S_BUSY) && (state_nxt == S_RECOVER);

  // Next-state decode; error beats timeout beats completion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_START;
      S_START:   state_nxt = S_BUSY;
      S_BUSY: begin
        if (engine_err || busy_timeout) state_nxt = S_RECOVER;
        else if (seen_low && engine_att) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_GAP;
      S_RECOVER: if (rec_done) state_nxt = S_GAP;
      S_GAP:     if (gap_done) state_nxt = enable ? S_START : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ATT routing: only the served port sees the engine while a transaction is live
  always_comb begin
    port_att_n = 2'b11;
    if (state == S_START || state == S_BUSY || state == S_CAPTURE)
      port_att_n[port_sel] = engine_att;
  end

  // FSM state, counter, completion tracking and engine control strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 20'd0;
      seen_low     <= 1'b0;
      port_sel     <= 1'b0;
      engine_start <= 1'b0;
      engine_rst   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) cnt <= 20'd0;
      else cnt <= cnt + 20'd1;
      // seen_low guards against ATT still being high right after the start pulse
      if (state == S_START) seen_low <= 1'b0;
      else if (state == S_BUSY && !engine_att) seen_low <= 1'b1;
      if (state == S_GAP && gap_done) port_sel <= port1_en ? ~port_sel : 1'b0;
      // Strobes are registered from the next state so they are glitch-free
      engine_start <= (state_nxt == S_START);
      engine_rst   <= (state_nxt == S_RECOVER);
    end
  end

  // Per-port snapshot capture, valid/update flags and failure counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn0     <= 16'hFFFF;
      btn1     <= 16'hFFFF;
      joy0     <= 32'h80808080;
      joy1     <= 32'h80808080;
      type0    <= 4'd0;
      type1    <= 4'd0;
      valid    <= 2'b00;
      upd      <= 2'b00;
      err_cnt0 <= 8'd0;
      err_cnt1 <= 8'd0;
    end else begin
      upd <= 2'b00;
      if (state == S_CAPTURE) begin
        valid[port_sel] <= 1'b1;
        upd[port_sel]   <= 1'b1;
        if (port_sel) begin
          btn1  <= engine_btn;
          joy1  <= engine_joy;
          type1 <= engine_type;
        end else begin
          btn0  <= engine_btn;
          joy0  <= engine_joy;
          type0 <= engine_type;
        end
      end
      // A failed transaction invalidates the port but keeps its last snapshot
      if (enter_recover) begin
        valid[port_sel] <= 1'b0;
        if (port_sel) begin
          if (err_cnt1 != 8'hFF) err_cnt1 <= err_cnt1 + 8'd1;
        end else begin
          if (err_cnt0 != 8'hFF) err_cnt0 <= err_cnt0 + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pad_poll_scheduler.sv
// tb/tb_pad_poll_scheduler.sv - randomized scoreboard bench for pad_poll_scheduler
`timescale 1ns/1ps
module tb_pad_poll_scheduler;

  localparam int GAP = 12;
  localparam int TMO = 120;
  localparam int RST = 4;
  localparam int M_GOOD = 0;
  localparam int M_ERR  = 1;
  localparam int M_TMO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        port1_en = 1'b0;
  logic        engine_att = 1'b1;
  logic        engine_err = 1'b0;
  logic [15:0] engine_btn = 16'hFFFF;
  logic [31:0] engine_joy = 32'h80808080;
  logic [3:0]  engine_type = 4'd0;
  logic        engine_start, engine_rst, port_sel;
  logic [1:0]  port_att_n, valid, upd;
  logic [15:0] btn0, btn1;
  logic [31:0] joy0, joy1;
  logic [3:0]  type0, type1;
  logic [7:0]  err_cnt0, err_cnt1;

  pad_poll_scheduler #(
    .GAP_CYCLES(16'(GAP)), .TIMEOUT_CYCLES(20'(TMO)), .RST_CYCLES(4'(RST))
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .port1_en(port1_en),
    .engine_att(engine_att), .engine_err(engine_err), .engine_btn(engine_btn),
    .engine_joy(engine_joy), .engine_type(engine_type),
    .engine_start(engine_start), .engine_rst(engine_rst), .port_sel(port_sel),
    .port_att_n(port_att_n), .btn0(btn0), .btn1(btn1), .joy0(joy0), .joy1(joy1),
    .type0(type0), .type1(type1), .valid(valid), .upd(upd),
    .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int          kind;
    logic        port;
    logic [15:0] b0, b1;
    logic [31:0] j0, j1;
    logic [3:0]  t0, t1;
    logic [1:0]  v;
    logic [7:0]  e0, e1;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_btn[2];
  logic [31:0] m_joy[2];
  logic [3:0]  m_typ[2];
  logic [1:0]  m_val;
  int          m_err[2];
  logic        exp_port;
  int          exp_next_start;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_btn = '{16'hFFFF, 16'hFFFF};
    m_joy = '{32'h80808080, 32'h80808080};
    m_typ = '{4'd0, 4'd0};
    m_val = 2'b00;
    m_err = '{0, 0};
    exp_port = 1'b0;
    q.delete();
  endtask

  task automatic push(input int kind);
    exp_t e;
    e.kind = kind; e.port = exp_port;
    e.b0 = m_btn[0]; e.b1 = m_btn[1];
    e.j0 = m_joy[0]; e.j1 = m_joy[1];
    e.t0 = m_typ[0]; e.t1 = m_typ[1];
    e.v = m_val; e.e0 = 8'(m_err[0]); e.e1 = 8'(m_err[1]);
    q.push_back(e);
  endtask

  task automatic model_fail();
    m_err[exp_port] = (m_err[exp_port] < 255) ? m_err[exp_port] + 1 : 255;
    m_val[exp_port] = 1'b0;
  endtask

  task automatic cmp_snap(input string tag, input exp_t e);
    check({tag, "_btn"}, {btn1, btn0}, {e.b1, e.b0});
    check({tag, "_joy"}, {joy1, joy0}, {e.j1, e.j0});
    check({tag, "_type"}, {type1, type0}, {e.t1, e.t0});
    check({tag, "_valid"}, valid, e.v);
    check({tag, "_errcnt"}, {err_cnt1, err_cnt0}, {e.e1, e.e0});
  endtask

  // Monitor: pops the scoreboard on every snapshot update or recovery entry
  initial begin
    exp_t e;
    logic rst_q;
    int   rst_len;
    rst_q = 1'b0;
    rst_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rst_q = 1'b0;
        rst_len = 0;
      end else begin
        if (engine_start && engine_rst) check("start_rst_overlap", 1, 0);
        if (upd != 2'b00) begin
          if (q.size() == 0) check("upd_unexpected", upd, 2'b00);
          else begin
            e = q.pop_front();
            check("upd_kind", e.kind, M_GOOD);
            check("upd_port", upd, e.port ? 2'b10 : 2'b01);
            cmp_snap("upd", e);
          end
        end
        if (engine_rst && !rst_q) begin
          if (q.size() == 0) check("rst_unexpected", engine_rst, 0);
          else begin
            e = q.pop_front();
            check("rst_kind_is_fail", e.kind != M_GOOD, 1);
            check("rst_port", port_sel, e.port);
            check("rst_att_idle", port_att_n, 2'b11);
            cmp_snap("rst", e);
          end
        end
        if (engine_rst) rst_len++;
        else if (rst_q) begin
          check("rst_len", rst_len, RST);
          rst_len = 0;
        end
        rst_q = engine_rst;
      end
    end
  end

  task automatic wait_start(input int budget, input logic want, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (engine_start) found = 1'b1;
    end
    check(want ? "start_seen" : "start_while_parked", found, want);
    if (found && exp_next_start >= 0) check("start_interval", cyc, exp_next_start);
  endtask

  // One engine transaction as seen from the engine side, plus model update
  task automatic txn(input int mode, input logic p1, input logic [15:0] b,
                     input logic [31:0] j, input logic [3:0] t, input int low_len,
                     input logic dis);
    int   s;
    int   d;
    logic found;
    wait_start(TMO + GAP + RST + 40, 1'b1, found);
    if (found) begin
      s = cyc;
      check("start_port", port_sel, exp_port);
      port1_en = p1;
      @(posedge clk); #1;
      check("start_one_cycle", engine_start, 0);
      if (mode == M_TMO) begin
        model_fail();
        push(M_TMO);
        exp_next_start = s + TMO + RST + GAP + 1;
      end else begin
        d = $urandom_range(0, 3);
        repeat (d) begin
          engine_btn = 16'($urandom);
          @(posedge clk); #1;
        end
        engine_att = 1'b0;
        if (dis) enable = 1'b0;
        #1 check("att_route", port_att_n, exp_port ? 2'b01 : 2'b10);
        repeat (low_len) begin
          @(posedge clk); #1;
          engine_btn = 16'($urandom);
          engine_joy = $urandom;
        end
        if (mode == M_GOOD) begin
          engine_att = 1'b1;
          engine_btn = b; engine_joy = j; engine_type = t;
          m_btn[exp_port] = b; m_joy[exp_port] = j; m_typ[exp_port] = t;
          m_val[exp_port] = 1'b1;
          push(M_GOOD);
          exp_next_start = cyc + GAP + 2;
          repeat (3) @(posedge clk);
          #1 check("gap_att_idle", port_att_n, 2'b11);
        end else begin
          engine_err = 1'b1;
          model_fail();
          push(M_ERR);
          exp_next_start = cyc + RST + GAP + 1;
          @(posedge clk); #1;
          engine_err = 1'b0;
          engine_att = 1'b1;
        end
      end
      exp_port = p1 ? ~exp_port : 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d exceeded limit", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", engine_start, 0);
    check("rst_erst", engine_rst, 0);
    check("rst_port_sel", port_sel, 0);
    check("rst_att", port_att_n, 2'b11);
    check("rst_btn", {btn1, btn0}, 32'hFFFFFFFF);
    check("rst_joy", {joy1, joy0}, 64'h8080808080808080);
    check("rst_type", {type1, type0}, 8'h00);
    check("rst_valid_upd", {valid, upd}, 4'b0000);
    check("rst_errcnt", {err_cnt1, err_cnt0}, 16'h0000);

    rst_n = 1'b1;
    enable = 1'b1;
    exp_next_start = cyc + 1;
    txn(M_GOOD, 1'b0, 16'hFFEF, 32'h80808080, 4'b0001, 100, 1'b0);
    txn(M_GOOD, 1'b1, 16'($urandom), $urandom, 4'b0010, 20, 1'b0);
    txn(M_GOOD, 1'b1, 16'($urandom), $urandom, 4'b0100, 15, 1'b0);
    txn(M_GOOD, 1'b1, 16'($urandom), $urandom, 4'b1000, 30, 1'b0);
    txn(M_ERR,  1'b1, 16'h0, 32'h0, 4'h0, 5, 1'b0);
    txn(M_GOOD, 1'b0, 16'($urandom), $urandom, 4'b0001, 8, 1'b0);

    for (int i = 0; i < 12; i++)
      txn(int'($urandom_range(0, 1)), 1'($urandom), 16'($urandom), $urandom,
          4'($urandom), int'($urandom_range(1, 40)), 1'b0);
    txn(M_GOOD, 1'b1, 16'($urandom), $urandom, 4'b0001, 10, 1'b0);
    txn(M_GOOD, 1'b0, 16'($urandom), $urandom, 4'b0010, 10, 1'b0);

    txn(M_GOOD, 1'b0, 16'h1234, 32'h11223344, 4'b0100, 25, 1'b1);
    wait_start(GAP * 4, 1'b0, found);
    check("parked_att", port_att_n, 2'b11);
    check("parked_erst", engine_rst, 0);
    enable = 1'b1;
    exp_next_start = cyc + 1;

    for (int i = 0; i < 300; i++)
      txn(M_TMO, 1'b0, 16'h0, 32'h0, 4'h0, 0, 1'b0);
    repeat (TMO + RST + 3) @(posedge clk);
    #1 check("errcnt0_saturated", err_cnt0, 8'hFF);

    txn(M_GOOD, 1'b1, 16'($urandom), $urandom, 4'b0001, 12, 1'b0);
    wait_start(TMO + GAP + RST + 40, 1'b1, found);
    check("pre_reset_port", port_sel, 1'b1);
    @(posedge clk); #1;
    engine_att = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_start", engine_start, 0);
    check("arst_erst", engine_rst, 0);
    check("arst_port_sel", port_sel, 0);
    check("arst_att", port_att_n, 2'b11);
    check("arst_btn", {btn1, btn0}, 32'hFFFFFFFF);
    check("arst_joy", {joy1, joy0}, 64'h8080808080808080);
    check("arst_type", {type1, type0}, 8'h00);
    check("arst_valid_upd", {valid, upd}, 4'b0000);
    check("arst_errcnt", {err_cnt1, err_cnt0}, 16'h0000);
    @(posedge clk); #1;
    check("arst_hold_start", engine_start, 0);
    engine_att = 1'b1;
    model_reset();
    rst_n = 1'b1;
    exp_next_start = cyc + 1;
    txn(M_GOOD, 1'b0, 16'hFFEF, 32'h7F807F80, 4'b0001, 18, 1'b0);

    repeat (GAP + 10) @(posedge clk);
    #1 check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
